// File: rtl/operand_fetch_ctrl_pkg.sv
// operand_fetch_ctrl_pkg: state encoding, field codes and entry-state decode for the operand fetch sequencer
package operand_fetch_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, S_EXT, S_ADR, S_RD, D_EXT, D_ADR, D_RD, VALID} state_e;
  localparam logic [3:0] PC_REG = 4'd0;
  localparam logic [3:0] SR_REG = 4'd2;
  localparam logic [3:0] CG_REG = 4'd3;
  localparam logic [1:0] FMT_TWO = 2'b00;
  localparam logic [1:0] FMT_ONE = 2'b01;
  localparam logic [1:0] AS_REG = 2'b00;
  localparam logic [1:0] AS_IDX = 2'b01;
  localparam logic [1:0] AS_INC = 2'b11;
  localparam logic [1:0] ADDR_ABS = 2'd0;
  localparam logic [1:0] ADDR_RSRC = 2'd2;
  function automatic logic is_cg(input logic [3:0] rs, input logic [1:0] as_m);
    return rs == CG_REG || (rs == SR_REG && as_m[1]);
  endfunction
  // Jump formats (fmt[1]=1) and constant-generator sources never touch memory.
  function automatic state_e first_state(input logic [1:0] fmt, input logic [1:0] as_m,
                                         input logic ad, input logic [3:0] rs);
    logic src_mem;
    src_mem = !fmt[1] && as_m != AS_REG && !is_cg(rs, as_m);
    return src_mem ? (as_m == AS_IDX ? S_EXT : S_RD) : (fmt == FMT_TWO && ad) ? D_EXT : VALID;
  endfunction
endpackage

// File: rtl/operand_fetch_ctrl.sv
// operand_fetch_ctrl: sequences src/dst operand fetch (ext word, index add, memory read) for the execute stage
module operand_fetch_ctrl
  import operand_fetch_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [1:0] fmt_i,
  input  logic [1:0] as_mode_i,
  input  logic       ad_mode_i,
  input  logic [3:0] rs_i,
  input  logic [3:0] rd_i,
  input  logic       bw_i,
  input  logic       mem_rdy_i,
  input  logic       exec_ack_i,
  output logic [3:0] rsrc_sel_o,
  output logic       src_m_o,
  output logic       src_l_o,
  output logic       dst_m_o,
  output logic       dst_l_o,
  output logic [1:0] addr_m_o,
  output logic       addr_l_o,
  output logic       idx_m_o,
  output logic       mem_rd_o,
  output logic       pc_inc_o,
  output logic [1:0] rs_inc_o,
  output logic       op_valid_o,
  output logic       busy_o
);
  state_e     state_q, state_d;
  logic [1:0] fmt_q, as_q;
  logic       ad_q, bw_q, src_m_q, src_m_d, dst_m_q, dst_m_d;
  logic [3:0] rs_q;
  logic       one_op, dst_mem, unused_rd;
  // Rd only steers the datapath register file directly; the sequencer never needs it.
  assign unused_rd = ^rd_i;
  assign one_op    = fmt_q == FMT_ONE;
  assign dst_mem   = fmt_q == FMT_TWO && ad_q;
  assign busy_o    = state_q != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fmt_q   <= '0;
      as_q    <= '0;
      ad_q    <= 1'b0;
      rs_q    <= '0;
      bw_q    <= 1'b0;
      src_m_q <= 1'b0;
      dst_m_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_m_q <= src_m_d;
      dst_m_q <= dst_m_d;
      if (state_q == IDLE && start_i) begin
        fmt_q <= fmt_i;
        as_q  <= as_mode_i;
        ad_q  <= ad_mode_i;
        rs_q  <= rs_i;
        bw_q  <= bw_i;
      end
    end
  end
  always_comb begin
    state_d    = state_q;
    src_m_d    = src_m_q;
    dst_m_d    = dst_m_q;
    rsrc_sel_o = '0;
    src_m_o    = src_m_q;
    src_l_o    = 1'b0;
    dst_m_o    = dst_m_q;
    dst_l_o    = 1'b0;
    addr_m_o   = ADDR_ABS;
    addr_l_o   = 1'b0;
    idx_m_o    = 1'b0;
    mem_rd_o   = 1'b0;
    pc_inc_o   = 1'b0;
    rs_inc_o   = '0;
    op_valid_o = 1'b0;
    case (state_q)
      IDLE: state_d = start_i ? first_state(fmt_i, as_mode_i, ad_mode_i, rs_i) : IDLE;
      S_EXT, D_EXT: begin
        rsrc_sel_o = PC_REG;
        addr_m_o   = ADDR_RSRC;
        mem_rd_o   = 1'b1;
        pc_inc_o   = mem_rdy_i;
        state_d    = !mem_rdy_i ? state_q : state_q == S_EXT ? S_ADR : D_ADR;
      end
      S_ADR: begin
        rsrc_sel_o = rs_q;
        addr_l_o   = 1'b1;
        state_d    = S_RD;
      end
      S_RD: begin
        rsrc_sel_o = rs_q;
        addr_m_o   = as_q == AS_IDX ? ADDR_ABS : ADDR_RSRC;
        mem_rd_o   = 1'b1;
        src_m_o    = 1'b1;
        dst_m_o    = dst_m_q | one_op;
        if (mem_rdy_i) begin
          src_l_o  = 1'b1;
          dst_l_o  = one_op;
          rs_inc_o = as_q != AS_INC ? 2'd0 : (rs_q == PC_REG || !bw_q) ? 2'd2 : 2'd1;
          src_m_d  = 1'b1;
          dst_m_d  = dst_m_q | one_op;
          state_d  = dst_mem ? D_EXT : VALID;
        end
      end
      D_ADR: begin
        addr_l_o = 1'b1;
        idx_m_o  = 1'b1;
        state_d  = D_RD;
      end
      D_RD: begin
        mem_rd_o = 1'b1;
        dst_m_o  = 1'b1;
        if (mem_rdy_i) begin
          dst_l_o = 1'b1;
          dst_m_d = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        op_valid_o = 1'b1;
        if (exec_ack_i) begin
          state_d = IDLE;
          src_m_d = 1'b0;
          dst_m_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
